// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding a UART transmitter with a DV/done handshake.
// Optional i_Flush port when UART_TXQ_FLUSH_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
`ifdef UART_TXQ_FLUSH_EN
  input  logic                  i_Flush,
`endif
  input  logic                  i_Wr_En,
  input  logic [7:0]            i_Wr_Data,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  state_t                state_q;
  logic                  dv_q;
  logic [7:0]            byte_q;
  logic                  busy_q;

  logic flush, full, empty, push, pop;

`ifdef UART_TXQ_FLUSH_EN
  assign flush = i_Flush;
`else
  assign flush = 1'b0;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Full is taken from the registered count, so a pop cannot
  // make room for a write in the same cycle.
  assign push = i_Wr_En && !full && !flush;
  assign pop  = (state_q == S_IDLE) && !empty &&
                !i_Tx_Active && !i_Tx_Done;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = i_Wr_En && full && !flush;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            byte_q  <= mem_q[rd_ptr_q];
            dv_q    <= 1'b1;
            state_q <= S_SEND;
            busy_q  <= 1'b1;
          end
        end
        S_SEND: begin
          state_q <= S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (i_Tx_Active) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) state_q <= S_DRAIN;
        end
        // Hold off until done drops so the next DV meets an idle TX.
        S_DRAIN: begin
          if (!i_Tx_Done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = busy_q;

endmodule
